// File: rtl/gcc_arb.sv
// ---------------------------------------------------------------------------
// gcc_arb
//
// Shares one GCC weighted-centroid core between two requesters, A and B.
// A granted requester streams one group of GROUP points (X, Y, W) into the
// core on consecutive cycles. The arbiter then waits for the core's active-low
// result strobe, latches the centroid and hands it back to the requester
// together with a one-cycle DONE pulse. Arbitration is round-robin when both
// sides request at once. A watchdog declares the core hung after TIMEOUT wait
// cycles; it then pulses the core reset and returns an all-ones result.
//
// Ports
//   CLK, RESET        clock, synchronous active-high reset
//   REQ_A/XA/YA/WA    requester A request and current point
//   GNT_A             high for GROUP cycles; each cycle consumes one A point
//   REQ_B/XB/YB/WB    requester B request and current point
//   GNT_B             high for GROUP cycles; each cycle consumes one B point
//   Xi, Yi, Wi        point presented to the core (zero outside FEED)
//   CORE_RST_         active-low core reset
//   READY_            core result strobe, active low for one cycle
//   Xc, Yc            core result
//   RES_X, RES_Y      latched result returned to the requester
//   DONE_A, DONE_B    one-cycle pulse marking whose result RES_X/RES_Y is
//   BUSY              high in every state except IDLE
//   ERR               sticky watchdog flag, cleared only by RESET
// ---------------------------------------------------------------------------
module gcc_arb #(
   parameter int GROUP   = 3,
   parameter int TIMEOUT = 64,
   parameter int DW      = 8,
   parameter int WW      = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          REQ_A,
   input  logic [DW-1:0] XA,
   input  logic [DW-1:0] YA,
   input  logic [WW-1:0] WA,
   output logic          GNT_A,
   input  logic          REQ_B,
   input  logic [DW-1:0] XB,
   input  logic [DW-1:0] YB,
   input  logic [WW-1:0] WB,
   output logic          GNT_B,
   output logic [DW-1:0] Xi,
   output logic [DW-1:0] Yi,
   output logic [WW-1:0] Wi,
   output logic          CORE_RST_,
   input  logic          READY_,
   input  logic [DW-1:0] Xc,
   input  logic [DW-1:0] Yc,
   output logic [DW-1:0] RES_X,
   output logic [DW-1:0] RES_Y,
   output logic          DONE_A,
   output logic          DONE_B,
   output logic          BUSY,
   output logic          ERR
);

   // Counter widths: the feed counter must reach GROUP-1, the wait counter
   // must reach TIMEOUT-1.
   localparam int FCW = (GROUP > 1) ? $clog2(GROUP) : 1;
   localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [FCW-1:0] FEED_LAST = FCW'(GROUP - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FEED  = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      FLUSH = 3'd4
   } state_t;

   state_t          state;
   state_t          next_state;
   logic            grant_b;
   logic            next_grant_b;
   logic            prefer_b;
   logic [FCW-1:0]  feed_cnt;
   logic [WCW-1:0]  wait_cnt;
   logic [DW-1:0]   res_x;
   logic [DW-1:0]   res_y;
   logic            err_flag;
   logic            core_hold;
   logic            result_hit;
   logic            timeout_hit;

   // A result strobe in WAIT always beats the watchdog, even on the very
   // last permitted wait cycle.
   assign result_hit  = (state == WAIT) && !READY_;
   assign timeout_hit = (state == WAIT) && READY_ && (wait_cnt == WAIT_LAST);

   // State register. grant_b records which side owns the current group; it
   // only changes when a new group is granted out of IDLE.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         grant_b <= 1'b0;
      end else begin
         state   <= next_state;
         grant_b <= next_grant_b;
      end
   end

   // Next-state logic. With both sides requesting, prefer_b picks the side
   // that was not served last; a lone requester is granted directly.
   always_comb begin
      next_state   = state;
      next_grant_b = grant_b;
      unique case (state)
         IDLE: begin
            if (REQ_A || REQ_B) begin
               next_state = FEED;
               if (REQ_A && REQ_B) begin
                  next_grant_b = prefer_b;
               end else begin
                  next_grant_b = REQ_B;
               end
            end
         end
         FEED: begin
            if (feed_cnt == FEED_LAST) begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (result_hit) begin
               next_state = DONE;
            end else if (timeout_hit) begin
               next_state = FLUSH;
            end
         end
         DONE:    next_state = IDLE;
         FLUSH:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Point counter: zero on entry to FEED, one step per consumed point.
   always_ff @(posedge CLK) begin
      if (RESET || (state != FEED)) begin
         feed_cnt <= '0;
      end else begin
         feed_cnt <= feed_cnt + FCW'(1);
      end
   end

   // Watchdog counter: zero on entry to WAIT, one step per waited cycle.
   always_ff @(posedge CLK) begin
      if (RESET || (state != WAIT)) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + WCW'(1);
      end
   end

   // Result registers hold until the next latch; a hung core reports all ones
   // so the requester can tell a flushed group from a real centroid.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         res_x <= '0;
         res_y <= '0;
      end else if (result_hit) begin
         res_x <= Xc;
         res_y <= Yc;
      end else if (timeout_hit) begin
         res_x <= '1;
         res_y <= '1;
      end
   end

   // Sticky error flag; only RESET clears it.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         err_flag <= 1'b0;
      end else if (timeout_hit) begin
         err_flag <= 1'b1;
      end
   end

   // Round-robin pointer: after a group finishes (normally or flushed) the
   // other side is preferred. Out of reset A is preferred.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prefer_b <= 1'b0;
      end else if ((state == DONE) || (state == FLUSH)) begin
         prefer_b <= ~grant_b;
      end
   end

   // Keeps the core in reset for the cycle after a RESET edge as well, so an
   // aborted group never leaves partial sums inside the core.
   always_ff @(posedge CLK) begin
      core_hold <= RESET;
   end

   // Output decode. Everything is forced to its reset value while RESET is
   // high, so an abort takes effect immediately at the ports. Point data is a
   // zero-latency mux because the core samples it on the same edge as the
   // requester advances.
   always_comb begin
      GNT_A     = 1'b0;
      GNT_B     = 1'b0;
      Xi        = '0;
      Yi        = '0;
      Wi        = '0;
      DONE_A    = 1'b0;
      DONE_B    = 1'b0;
      RES_X     = '0;
      RES_Y     = '0;
      BUSY      = 1'b0;
      ERR       = 1'b0;
      CORE_RST_ = 1'b0;
      if (!RESET) begin
         RES_X     = res_x;
         RES_Y     = res_y;
         ERR       = err_flag;
         BUSY      = (state != IDLE);
         CORE_RST_ = !core_hold;
         unique case (state)
            FEED: begin
               GNT_A = !grant_b;
               GNT_B = grant_b;
               Xi    = grant_b ? XB : XA;
               Yi    = grant_b ? YB : YA;
               Wi    = grant_b ? WB : WA;
            end
            DONE: begin
               DONE_A = !grant_b;
               DONE_B = grant_b;
            end
            FLUSH: begin
               DONE_A    = !grant_b;
               DONE_B    = grant_b;
               CORE_RST_ = 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcc_arb.sv
// ---------------------------------------------------------------------------
// tb_gcc_arb
//
// Bench for gcc_arb. Two requester processes stream points from a table of
// groups, a small core process computes the integer weighted centroid of the
// points it actually receives, and a monitor compares every DONE against a
// per-side scoreboard filled when the group was queued.
// ---------------------------------------------------------------------------
module tb_gcc_arb;

   localparam int GROUP   = 3;
   localparam int TIMEOUT = 64;
   localparam int DW      = 8;
   localparam int WW      = 4;
   localparam int NVEC    = 9;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          REQ_A = 1'b0;
   logic [DW-1:0] XA = '0;
   logic [DW-1:0] YA = '0;
   logic [WW-1:0] WA = '0;
   logic          GNT_A;
   logic          REQ_B = 1'b0;
   logic [DW-1:0] XB = '0;
   logic [DW-1:0] YB = '0;
   logic [WW-1:0] WB = '0;
   logic          GNT_B;
   logic [DW-1:0] Xi;
   logic [DW-1:0] Yi;
   logic [WW-1:0] Wi;
   logic          CORE_RST_;
   logic          READY_ = 1'b1;
   logic [DW-1:0] Xc = '0;
   logic [DW-1:0] Yc = '0;
   logic [DW-1:0] RES_X;
   logic [DW-1:0] RES_Y;
   logic          DONE_A;
   logic          DONE_B;
   logic          BUSY;
   logic          ERR;

   gcc_arb #(.GROUP(GROUP), .TIMEOUT(TIMEOUT), .DW(DW), .WW(WW)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ_A(REQ_A), .XA(XA), .YA(YA), .WA(WA), .GNT_A(GNT_A),
      .REQ_B(REQ_B), .XB(XB), .YB(YB), .WB(WB), .GNT_B(GNT_B),
      .Xi(Xi), .Yi(Yi), .Wi(Wi), .CORE_RST_(CORE_RST_),
      .READY_(READY_), .Xc(Xc), .Yc(Yc),
      .RES_X(RES_X), .RES_Y(RES_Y), .DONE_A(DONE_A), .DONE_B(DONE_B),
      .BUSY(BUSY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic                          side_b;
      logic [GROUP-1:0][DW-1:0]      x;
      logic [GROUP-1:0][DW-1:0]      y;
      logic [GROUP-1:0][WW-1:0]      w;
      logic [DW-1:0]                 exp_x;
      logic [DW-1:0]                 exp_y;
   } vec_t;

   typedef struct {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic          err;
   } exp_t;

   vec_t vecs [NVEC];
   exp_t exp_q_a [$];
   exp_t exp_q_b [$];
   int   grp_q_a [$];
   int   grp_q_b [$];
   int   grant_log [$];
   logic [DW-1:0] xi_log [$];

   int nvec = 0;
   int nerr = 0;
   int done_cnt = 0;
   int gnt_a_cyc = 0;
   int gnt_b_cyc = 0;
   int core_delay = 1;
   int stray_at = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void set_vec(input int i, input logic sb,
      input logic [DW-1:0] x0, input logic [DW-1:0] y0, input logic [WW-1:0] w0,
      input logic [DW-1:0] x1, input logic [DW-1:0] y1, input logic [WW-1:0] w1,
      input logic [DW-1:0] x2, input logic [DW-1:0] y2, input logic [WW-1:0] w2,
      input logic [DW-1:0] ex, input logic [DW-1:0] ey);
      vecs[i].side_b = sb;
      vecs[i].x      = {x2, x1, x0};
      vecs[i].y      = {y2, y1, y0};
      vecs[i].w      = {w2, w1, w0};
      vecs[i].exp_x  = ex;
      vecs[i].exp_y  = ey;
   endfunction

   // Queues one table group on its side and records the expected result.
   task automatic applyStimulus(input int idx, input logic exp_err, input logic hang);
      exp_t e;
      e.x   = hang ? {DW{1'b1}} : vecs[idx].exp_x;
      e.y   = hang ? {DW{1'b1}} : vecs[idx].exp_y;
      e.err = exp_err;
      if (vecs[idx].side_b) begin
         exp_q_b.push_back(e);
         grp_q_b.push_back(idx);
      end else begin
         exp_q_a.push_back(e);
         grp_q_a.push_back(idx);
      end
   endtask

   task automatic wait_done(input int n, input int budget);
      int start;
      int cyc;
      start = done_cnt;
      cyc = 0;
      while ((done_cnt < start + n) && (cyc < budget)) begin
         @(negedge CLK);
         cyc++;
      end
      checkOutput("done count within budget", done_cnt - start, n);
   endtask

   task automatic pulse_reset();
      @(posedge CLK);
      #1 RESET = 1'b1;
      @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
   endtask

   // Requester A: advances one point per granted cycle, drops a group on reset.
   initial begin : req_a_proc
      int   pt;
      logic g;
      logic r;
      pt = 0;
      forever begin
         @(negedge CLK);
         g = GNT_A;
         r = RESET;
         @(posedge CLK);
         #1;
         if (r) begin
            grp_q_a.delete();
            pt = 0;
         end else if (g && (grp_q_a.size() > 0)) begin
            pt++;
            if (pt == GROUP) begin
               grp_q_a.delete(0);
               pt = 0;
            end
         end
         if (grp_q_a.size() > 0) begin
            REQ_A = 1'b1;
            XA = vecs[grp_q_a[0]].x[pt];
            YA = vecs[grp_q_a[0]].y[pt];
            WA = vecs[grp_q_a[0]].w[pt];
         end else begin
            REQ_A = 1'b0;
            XA = '0;
            YA = '0;
            WA = '0;
         end
      end
   end

   // Requester B: same behaviour as A.
   initial begin : req_b_proc
      int   pt;
      logic g;
      logic r;
      pt = 0;
      forever begin
         @(negedge CLK);
         g = GNT_B;
         r = RESET;
         @(posedge CLK);
         #1;
         if (r) begin
            grp_q_b.delete();
            pt = 0;
         end else if (g && (grp_q_b.size() > 0)) begin
            pt++;
            if (pt == GROUP) begin
               grp_q_b.delete(0);
               pt = 0;
            end
         end
         if (grp_q_b.size() > 0) begin
            REQ_B = 1'b1;
            XB = vecs[grp_q_b[0]].x[pt];
            YB = vecs[grp_q_b[0]].y[pt];
            WB = vecs[grp_q_b[0]].w[pt];
         end else begin
            REQ_B = 1'b0;
            XB = '0;
            YB = '0;
            WB = '0;
         end
      end
   end

   // Core stand-in: sums the points it receives and strobes READY_ low
   // core_delay cycles after the last one (never, if core_delay < 0).
   initial begin : core_proc
      int   cnt;
      int   left;
      int   sx;
      int   sy;
      int   sw;
      logic pending;
      cnt = 0; left = 0; sx = 0; sy = 0; sw = 0; pending = 1'b0;
      forever begin
         @(negedge CLK);
         READY_ = 1'b1;
         if (!CORE_RST_) begin
            cnt = 0; sx = 0; sy = 0; sw = 0; pending = 1'b0;
         end else if (GNT_A || GNT_B) begin
            sx += int'(Xi) * int'(Wi);
            sy += int'(Yi) * int'(Wi);
            sw += int'(Wi);
            cnt++;
            if (cnt == stray_at) begin
               READY_ = 1'b0;
               Xc = 8'hEE;
               Yc = 8'hEE;
            end
            if (cnt == GROUP) begin
               pending = 1'b1;
               left = core_delay;
               cnt = 0;
            end
         end else if (pending && (left > 0)) begin
            left--;
            if (left == 0) begin
               READY_ = 1'b0;
               Xc = (sw != 0) ? DW'(sx / sw) : '0;
               Yc = (sw != 0) ? DW'(sy / sw) : '0;
               pending = 1'b0;
               sx = 0; sy = 0; sw = 0;
            end
         end
      end
   end

   // Monitor: grant logging, overlap check and scoreboard comparison on DONE.
   initial begin : monitor_proc
      logic prev_a;
      logic prev_b;
      exp_t e;
      prev_a = 1'b0;
      prev_b = 1'b0;
      forever begin
         @(negedge CLK);
         if (GNT_A || GNT_B) begin
            checkOutput("gnt overlap", {31'd0, GNT_A & GNT_B}, 32'd0);
         end
         if (GNT_A) begin
            gnt_a_cyc++;
            xi_log.push_back(Xi);
            if (!prev_a) grant_log.push_back(0);
         end
         if (GNT_B) begin
            gnt_b_cyc++;
            if (!prev_b) grant_log.push_back(1);
         end
         prev_a = GNT_A;
         prev_b = GNT_B;
         if (DONE_A || DONE_B) begin
            checkOutput("done overlap", {31'd0, DONE_A & DONE_B}, 32'd0);
            done_cnt++;
         end
         if (DONE_A) begin
            checkOutput("done_a expected", {31'd0, exp_q_a.size() > 0}, 32'd1);
            if (exp_q_a.size() > 0) begin
               e = exp_q_a.pop_front();
               checkOutput("done_a res_x", RES_X, e.x);
               checkOutput("done_a res_y", RES_Y, e.y);
               checkOutput("done_a err", ERR, e.err);
            end
         end
         if (DONE_B) begin
            checkOutput("done_b expected", {31'd0, exp_q_b.size() > 0}, 32'd1);
            if (exp_q_b.size() > 0) begin
               e = exp_q_b.pop_front();
               checkOutput("done_b res_x", RES_X, e.x);
               checkOutput("done_b res_y", RES_Y, e.y);
               checkOutput("done_b err", ERR, e.err);
            end
         end
      end
   end

   initial begin : main_proc
      int cyc;
      int low;
      int started;
      int start;
      int wait_cycles;
      int exp_xi [3];
      int exp_order [6];

      exp_xi    = '{10, 30, 50};
      exp_order = '{0, 1, 0, 1, 0, 1};

      //        idx side  x0   y0   w0   x1   y1   w1   x2   y2   w2   ex   ey
      set_vec(0, 1'b0,  10,  20,  1,   30,  40,  2,   50,  60,  3,   36,  46);
      set_vec(1, 1'b1, 100, 200,  1,  100, 200,  1,  100, 200,  1,  100, 200);
      set_vec(2, 1'b0,   0,   0,  0,  255, 255, 15,    0,   0,  0,  255, 255);
      set_vec(3, 1'b1,   1,   2,  3,    4,   5,  6,    7,   8,  9,    5,   6);
      set_vec(4, 1'b0, 200,  10,  2,   40,  90,  2,   60,  30,  4,   90,  40);
      set_vec(5, 1'b1,   9, 250,  1,    0,   0,  0,   21, 130,  2,   17, 170);
      set_vec(6, 1'b0,  12,  34,  5,   56,  78,  5,   90,  11,  5,   52,  41);
      set_vec(7, 1'b1, 255,   0, 15,  255,   0, 15,    0, 255, 15,  170,  85);
      set_vec(8, 1'b0,   5,   5,  1,    6,   6,  1,    7,   7,  1,    6,   6);

      // Reset values while RESET is held.
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      checkOutput("reset gnt_a", GNT_A, 0);
      checkOutput("reset gnt_b", GNT_B, 0);
      checkOutput("reset done", {DONE_A, DONE_B}, 0);
      checkOutput("reset busy", BUSY, 0);
      checkOutput("reset err", ERR, 0);
      checkOutput("reset res", {RES_X, RES_Y}, 0);
      checkOutput("reset core point", {Xi, Yi, Wi}, 0);
      checkOutput("reset core_rst_", CORE_RST_, 0);
      @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);

      // Solo A with the documented group and a 4-cycle core latency.
      $display("[TB] solo A");
      gnt_a_cyc = 0;
      gnt_b_cyc = 0;
      xi_log.delete();
      core_delay = 4;
      applyStimulus(0, 1'b0, 1'b0);
      wait_done(1, 100);
      checkOutput("solo gnt_a cycles", gnt_a_cyc, GROUP);
      checkOutput("solo gnt_b cycles", gnt_b_cyc, 0);
      checkOutput("solo xi count", xi_log.size(), 3);
      for (int i = 0; i < 3 && i < xi_log.size(); i++) begin
         checkOutput("solo xi value", xi_log[i], exp_xi[i]);
      end

      // Table sweep: every group alone on its side, varying core latency.
      $display("[TB] table sweep");
      for (int i = 0; i < NVEC; i++) begin
         core_delay = 1 + (i % 5);
         applyStimulus(i, 1'b0, 1'b0);
         wait_done(1, 100);
      end

      // Contention: three groups each side, both requesting together.
      $display("[TB] contention");
      pulse_reset();
      grant_log.delete();
      core_delay = 2;
      applyStimulus(4, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 1'b0);
      applyStimulus(6, 1'b0, 1'b0);
      applyStimulus(3, 1'b0, 1'b0);
      applyStimulus(8, 1'b0, 1'b0);
      applyStimulus(5, 1'b0, 1'b0);
      start = done_cnt;
      started = 0;
      low = 0;
      cyc = 0;
      while ((done_cnt < start + 6) && (cyc < 300)) begin
         @(negedge CLK);
         cyc++;
         if (BUSY) begin
            if ((started != 0) && (low > 0)) checkOutput("busy gap cycles", low, 1);
            started = 1;
            low = 0;
         end else begin
            low++;
         end
      end
      checkOutput("contention done count", done_cnt - start, 6);
      checkOutput("grant log size", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
         checkOutput("grant order", grant_log[i], exp_order[i]);
      end

      // Stray strobe in FEED cycle 2 must be ignored.
      $display("[TB] stray strobe");
      stray_at = 2;
      core_delay = 3;
      applyStimulus(7, 1'b0, 1'b0);
      wait_done(1, 100);
      stray_at = 0;

      // Result on the last permitted wait cycle wins over the watchdog.
      $display("[TB] boundary wait count");
      core_delay = TIMEOUT;
      applyStimulus(2, 1'b0, 1'b0);
      wait_done(1, 200);
      checkOutput("err after last-cycle result", ERR, 0);

      // Hung core: watchdog flush, then a normal group with ERR still set.
      $display("[TB] timeout");
      core_delay = -1;
      applyStimulus(3, 1'b1, 1'b1);
      cyc = 0;
      while (!GNT_B && (cyc < 50)) begin
         @(negedge CLK);
         cyc++;
      end
      while (GNT_B && (cyc < 100)) begin
         @(negedge CLK);
         cyc++;
      end
      wait_cycles = 0;
      while (!ERR && (cyc < 300)) begin
         wait_cycles++;
         @(negedge CLK);
         cyc++;
      end
      checkOutput("timeout wait cycles", wait_cycles, TIMEOUT);
      checkOutput("flush core_rst_", CORE_RST_, 0);
      checkOutput("flush done_b", DONE_B, 1);
      @(negedge CLK);
      checkOutput("after flush core_rst_", CORE_RST_, 1);
      checkOutput("after flush busy", BUSY, 0);
      core_delay = 4;
      applyStimulus(0, 1'b1, 1'b0);
      wait_done(1, 100);
      checkOutput("err sticky", ERR, 1);

      // Reset during the second FEED cycle aborts the group.
      $display("[TB] reset mid-feed");
      core_delay = 2;
      applyStimulus(8, 1'b0, 1'b0);
      cyc = 0;
      while (!GNT_A && (cyc < 50)) begin
         @(negedge CLK);
         cyc++;
      end
      checkOutput("gnt_a before reset", GNT_A, 1);
      @(posedge CLK);
      #1 RESET = 1'b1;
      exp_q_a.delete();
      @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      checkOutput("post-reset gnt", {GNT_A, GNT_B}, 0);
      checkOutput("post-reset busy", BUSY, 0);
      checkOutput("post-reset done", {DONE_A, DONE_B}, 0);
      checkOutput("post-reset core_rst_", CORE_RST_, 0);
      checkOutput("post-reset err", ERR, 0);
      checkOutput("post-reset res", {RES_X, RES_Y}, 0);
      checkOutput("post-reset core point", {Xi, Yi, Wi}, 0);
      grant_log.delete();
      applyStimulus(1, 1'b0, 1'b0);
      wait_done(1, 100);
      checkOutput("post-reset grant count", grant_log.size(), 1);
      if (grant_log.size() > 0) checkOutput("post-reset first grant", grant_log[0], 1);
      repeat (3) @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
